// File: rtl/lifo_stack.sv
// -----------------------------------------------------------------------------
// lifo_stack
//
// Push/pop stack with a single stack pointer. Pushes store with post-increment
// (mem[sp++] = d) and pops retrieve with pre-decrement (q = mem[--sp]).
// Requests are fire-and-forget: a refused push or pop does not change the
// pointer. It is reported only through the sticky overflow/underflow flags.
//
// Parameters
//   WIDTH : data word width in bits
//   DEPTH : number of entries (power of two, >= 2)
//   CW    : width of count, $clog2(DEPTH+1) (derived; do not override)
//
// Ports
//   clk       : sole clock, rising edge
//   rst       : synchronous active-high reset; has priority over push/pop
//   push      : store push_data this cycle
//   push_data : word to store
//   pop       : retrieve the top entry this cycle
//   pop_data  : registered popped word; holds until the next successful pop
//   pop_valid : one-cycle pulse, pop_data was updated by last cycle's pop
//   count     : current occupancy 0..DEPTH (equals the stack pointer)
//   empty     : count == 0
//   full      : count == DEPTH
//   overflow  : sticky, a push was refused while full
//   underflow : sticky, a pop was refused while empty
// -----------------------------------------------------------------------------
module lifo_stack #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             pop_valid,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    localparam int AW = $clog2(DEPTH);

    // Storage, not reset. Read through a registered port so it maps to block RAM.
    logic [WIDTH-1:0] mem [DEPTH];

    logic [CW-1:0]    sp_reg;
    logic [CW-1:0]    sp_next;
    logic [WIDTH-1:0] pop_data_reg;
    logic             pop_valid_reg;
    logic             pop_valid_next;
    logic             overflow_reg;
    logic             underflow_reg;

    logic             wr_en;
    logic [AW-1:0]    wr_idx;
    logic             rd_en;
    logic             bypass;
    logic             overflow_set;
    logic             underflow_set;

    // Index of the current top entry (sp-1). Only the low AW bits matter.
    // Subtracting in AW bits yields the same low bits as subtracting in CW bits.
    // The result is used only when sp >= 1.
    logic [AW-1:0]    top_idx;

    assign top_idx = sp_reg[AW-1:0] - AW'(1);

    assign count     = sp_reg;
    assign empty     = (sp_reg == '0);
    assign full      = (sp_reg == CW'(DEPTH));
    assign pop_data  = pop_data_reg;
    assign pop_valid = pop_valid_reg;
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;

    // Operation decode, evaluated from the registered pointer only.
    always_comb begin
        wr_en          = 1'b0;
        wr_idx         = sp_reg[AW-1:0];
        rd_en          = 1'b0;
        bypass         = 1'b0;
        sp_next        = sp_reg;
        pop_valid_next = 1'b0;
        overflow_set   = 1'b0;
        underflow_set  = 1'b0;

        unique case ({push, pop})
            2'b10: begin
                if (full) begin
                    overflow_set = 1'b1;
                end else begin
                    wr_en   = 1'b1;
                    sp_next = sp_reg + CW'(1);
                end
            end
            2'b01: begin
                if (empty) begin
                    underflow_set = 1'b1;
                end else begin
                    rd_en          = 1'b1;
                    pop_valid_next = 1'b1;
                    sp_next        = sp_reg - CW'(1);
                end
            end
            2'b11: begin
                pop_valid_next = 1'b1;
                if (empty) begin
                    // Nothing is stored, so the pushed word passes straight through.
                    bypass = 1'b1;
                end else begin
                    // Replace-top: the old top is read and the new word is
                    // written to the same slot. The pointer does not move.
                    rd_en  = 1'b1;
                    wr_en  = 1'b1;
                    wr_idx = top_idx;
                end
            end
            default: ;
        endcase
    end

    // Memory write port. A reset in the same cycle drops the request.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wr_idx] <= push_data;
        end
    end

    // Registered read port. During replace-top it reads first, so it returns
    // the value from before the write.
    always_ff @(posedge clk) begin
        if (rst) begin
            pop_data_reg <= '0;
        end else if (rd_en) begin
            pop_data_reg <= mem[top_idx];
        end else if (bypass) begin
            pop_data_reg <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp_reg        <= '0;
            pop_valid_reg <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            sp_reg        <= sp_next;
            pop_valid_reg <= pop_valid_next;
            if (overflow_set) begin
                overflow_reg <= 1'b1;
            end
            if (underflow_set) begin
                underflow_reg <= 1'b1;
            end
        end
    end

endmodule
